// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate formats, ID/EX slot layout.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_we;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        is_load;
        logic        illegal;
    } id_ex_t;

    // FENCE and SYSTEM are treated as I-format: they carry rs1/rd fields and an I immediate.
    function automatic imm_fmt_e decode_fmt(input logic [6:0] opcode);
        case (opcode)
            OP_LUI, OP_AUIPC:                           return FMT_U;
            OP_JAL:                                     return FMT_J;
            OP_BRANCH:                                  return FMT_B;
            OP_STORE:                                   return FMT_S;
            OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: return FMT_I;
            default:                                    return FMT_R;
        endcase
    endfunction

    function automatic logic opcode_legal(input logic [6:0] opcode);
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; bit numbering follows the instruction word.
import riscv_pkg::*;

module imm_gen (
    input  logic [31:7] i_instr,
    input  imm_fmt_e    i_fmt,
    output logic [31:0] o_imm
);

    always_comb begin
        o_imm = '0;
        case (i_fmt)
            FMT_I:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B:   o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                              i_instr[11:8], 1'b0};
            FMT_U:   o_imm = {i_instr[31:12], 12'b0};
            FMT_J:   o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                              i_instr[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage with a single ID/EX slot, load-use and writeback hazard detection.
// Optional feature macro: WB_BYPASS_EN (forward same-cycle writeback data into operands).
import riscv_pkg::*;

module id_stage #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush_i,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [31:0]     if_instr_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            ex_ready_i,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_rs1_o,
    output logic [XLEN-1:0] ex_rs2_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [4:0]      ex_rd_o,
    output logic            ex_rd_we_o,
    output logic [6:0]      ex_opcode_o,
    output logic [2:0]      ex_funct3_o,
    output logic            ex_funct7b5_o,
    output logic            ex_is_load_o,
    output logic            ex_illegal_o
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // ready never depends on valid on the same side, and the slot holds stable while
    // ex_valid_o=1 and ex_ready_i=0.
    logic        r_valid;
    id_ex_t      r_slot;
    id_ex_t      w_next;
    imm_fmt_e    w_fmt;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic        w_legal, w_use_rs1, w_use_rs2, w_has_rd;
    logic [31:0] w_imm_raw, w_op1, w_op2;
    logic        w_load_use, w_wb_hazard, w_slot_free, w_accept;

    assign w_opcode   = if_instr_i[6:0];
    assign w_rd       = if_instr_i[11:7];
    assign w_rs1      = if_instr_i[19:15];
    assign w_rs2      = if_instr_i[24:20];
    assign rs1_addr_o = w_rs1;
    assign rs2_addr_o = w_rs2;

    assign w_fmt     = decode_fmt(w_opcode);
    assign w_legal   = opcode_legal(w_opcode);
    assign w_use_rs1 = w_legal & (w_fmt != FMT_U) & (w_fmt != FMT_J);
    assign w_use_rs2 = w_legal & ((w_fmt == FMT_R) | (w_fmt == FMT_S) | (w_fmt == FMT_B));
    assign w_has_rd  = w_legal & (w_fmt != FMT_S) & (w_fmt != FMT_B);

    imm_gen u_imm_gen (
        .i_instr (if_instr_i[31:7]),
        .i_fmt   (w_fmt),
        .o_imm   (w_imm_raw)
    );

    assign w_load_use = r_valid & r_slot.is_load & (r_slot.rd != 5'd0) &
                        ((w_use_rs1 & (r_slot.rd == w_rs1)) | (w_use_rs2 & (r_slot.rd == w_rs2)));

`ifdef WB_BYPASS_EN
    assign w_wb_hazard = 1'b0;
    assign w_op1 = (w_rs1 == 5'd0) ? '0 :
                   (wb_en_i && wb_rd_i == w_rs1) ? wb_data_i : rs1_data_i;
    assign w_op2 = (w_rs2 == 5'd0) ? '0 :
                   (wb_en_i && wb_rd_i == w_rs2) ? wb_data_i : rs2_data_i;
`else
    logic w_unused_wb_data;
    assign w_unused_wb_data = ^wb_data_i;
    // Stall one cycle so the regfile read sees the completed write.
    assign w_wb_hazard = wb_en_i & (wb_rd_i != 5'd0) &
                         ((w_use_rs1 & (wb_rd_i == w_rs1)) | (w_use_rs2 & (wb_rd_i == w_rs2)));
    assign w_op1 = (w_rs1 == 5'd0) ? '0 : rs1_data_i;
    assign w_op2 = (w_rs2 == 5'd0) ? '0 : rs2_data_i;
`endif

    assign w_slot_free = !r_valid | ex_ready_i;
    assign if_ready_o  = w_slot_free & !w_load_use & !w_wb_hazard & !flush_i;
    assign w_accept    = if_valid_i & if_ready_o;

    always_comb begin
        w_next          = '0;
        w_next.pc       = if_pc_i;
        w_next.rs1      = w_op1;
        w_next.rs2      = w_op2;
        w_next.imm      = w_legal ? w_imm_raw : '0;
        w_next.rd       = w_has_rd ? w_rd : 5'd0;
        w_next.rd_we    = w_has_rd & (w_rd != 5'd0);
        w_next.opcode   = w_opcode;
        w_next.funct3   = if_instr_i[14:12];
        w_next.funct7b5 = if_instr_i[30];
        w_next.is_load  = (w_opcode == OP_LOAD);
        w_next.illegal  = !w_legal;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_slot    <= '0;
            r_slot.pc <= RESET_PC;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_slot  <= w_next;
        end else if (ex_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign ex_valid_o    = r_valid;
    assign ex_pc_o       = r_slot.pc;
    assign ex_rs1_o      = r_slot.rs1;
    assign ex_rs2_o      = r_slot.rs2;
    assign ex_imm_o      = r_slot.imm;
    assign ex_rd_o       = r_slot.rd;
    assign ex_rd_we_o    = r_slot.rd_we;
    assign ex_opcode_o   = r_slot.opcode;
    assign ex_funct3_o   = r_slot.funct3;
    assign ex_funct7b5_o = r_slot.funct7b5;
    assign ex_is_load_o  = r_slot.is_load;
    assign ex_illegal_o  = r_slot.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, hazards, stall, flush, writeback and reset behaviour.
module tb_id_stage;

    logic        clk;
    logic        reset_n;
    logic        flush_i;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [31:0] if_instr_i;
    logic [31:0] if_pc_i;
    logic [4:0]  rs1_addr_o, rs2_addr_o;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic        wb_en_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        ex_ready_i;
    logic        ex_valid_o;
    logic [31:0] ex_pc_o, ex_rs1_o, ex_rs2_o, ex_imm_o;
    logic [4:0]  ex_rd_o;
    logic        ex_rd_we_o;
    logic [6:0]  ex_opcode_o;
    logic [2:0]  ex_funct3_o;
    logic        ex_funct7b5_o;
    logic        ex_is_load_o;
    logic        ex_illegal_o;

    logic [31:0] regs [32];
    int          n_vec  = 0;
    int          n_miss = 0;

    id_stage dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush_i       (flush_i),
        .if_valid_i    (if_valid_i),
        .if_ready_o    (if_ready_o),
        .if_instr_i    (if_instr_i),
        .if_pc_i       (if_pc_i),
        .rs1_addr_o    (rs1_addr_o),
        .rs2_addr_o    (rs2_addr_o),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .wb_en_i       (wb_en_i),
        .wb_rd_i       (wb_rd_i),
        .wb_data_i     (wb_data_i),
        .ex_ready_i    (ex_ready_i),
        .ex_valid_o    (ex_valid_o),
        .ex_pc_o       (ex_pc_o),
        .ex_rs1_o      (ex_rs1_o),
        .ex_rs2_o      (ex_rs2_o),
        .ex_imm_o      (ex_imm_o),
        .ex_rd_o       (ex_rd_o),
        .ex_rd_we_o    (ex_rd_we_o),
        .ex_opcode_o   (ex_opcode_o),
        .ex_funct3_o   (ex_funct3_o),
        .ex_funct7b5_o (ex_funct7b5_o),
        .ex_is_load_o  (ex_is_load_o),
        .ex_illegal_o  (ex_illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model: x0 reads a nonzero junk value so operand zeroing is visible.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h1000_0000 + i;
            regs[0] <= 32'hBAD0_BAD0;
            regs[3] <= 32'h0;
        end else if (wb_en_i && wb_rd_i != 5'd0) begin
            regs[wb_rd_i] <= wb_data_i;
        end
    end
    assign rs1_data_i = regs[rs1_addr_o];
    assign rs2_data_i = regs[rs2_addr_o];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        if_valid_i = v;
        if_instr_i = instr;
        if_pc_i    = pc;
        #1;
    endtask

    initial begin
        reset_n = 1'b0; flush_i = 1'b0; if_valid_i = 1'b0; if_instr_i = '0; if_pc_i = '0;
        wb_en_i = 1'b0; wb_rd_i = '0; wb_data_i = '0; ex_ready_i = 1'b1;
        tick(); tick();
        check("rst_valid", ex_valid_o, 0);
        check("rst_pc", ex_pc_o, 32'h0);
        check("rst_imm", ex_imm_o, 0);
        check("rst_rdwe", ex_rd_we_o, 0);
        reset_n = 1'b1;
        tick();

        // 1: ADDI x5,x0,-1
        drive(1, 32'hFFF0_0293, 32'h40);
        check("addi_ready", if_ready_o, 1);
        tick();
        drive(0, 32'h0, 32'h0);
        check("addi_valid", ex_valid_o, 1);
        check("addi_imm", ex_imm_o, 32'hFFFF_FFFF);
        check("addi_rd", ex_rd_o, 5);
        check("addi_rdwe", ex_rd_we_o, 1);
        check("addi_pc", ex_pc_o, 32'h40);
        check("addi_rs1_x0", ex_rs1_o, 32'h0);
        check("addi_opc", ex_opcode_o, 7'h13);

        // 2: LW x6,0(x1) then ADD x7,x6,x2
        drive(1, 32'h0000_A303, 32'h44);
        check("lw_ready", if_ready_o, 1);
        tick();
        drive(1, 32'h0023_03B3, 32'h48);
        check("lw_isload", ex_is_load_o, 1);
        check("lw_funct3", ex_funct3_o, 3'd2);
        check("add_rs1_addr", rs1_addr_o, 5'd6);
        check("loaduse_ready", if_ready_o, 0);
        tick();
        check("bubble_valid", ex_valid_o, 0);
        check("after_bubble_ready", if_ready_o, 1);
        tick();
        check("add_valid", ex_valid_o, 1);
        check("add_pc", ex_pc_o, 32'h48);
        check("add_rs1", ex_rs1_o, 32'h1000_0006);
        check("add_rs2", ex_rs2_o, 32'h1000_0002);
        check("add_rd", ex_rd_o, 7);
        check("add_imm", ex_imm_o, 0);

        // 3: backpressure for 3 cycles, then LUI x1,0x12345 enters once
        ex_ready_i = 1'b0;
        drive(1, 32'h1234_50B7, 32'h4C);
        check("stall_ready", if_ready_o, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", ex_valid_o, 1);
            check("stall_pc", ex_pc_o, 32'h48);
            check("stall_rs1", ex_rs1_o, 32'h1000_0006);
            check("stall_ready_k", if_ready_o, 0);
        end
        ex_ready_i = 1'b1;
        #1;
        check("release_ready", if_ready_o, 1);
        tick();
        drive(0, 32'h0, 32'h0);
        check("lui_pc", ex_pc_o, 32'h4C);
        check("lui_imm", ex_imm_o, 32'h1234_5000);
        check("lui_rd", ex_rd_o, 1);
        tick();
        check("no_dup_valid", ex_valid_o, 0);

        // 4: SW x2,-8(x1) held, then flush while IF offers JAL x1,+2048
        ex_ready_i = 1'b0;
        drive(1, 32'hFE20_AC23, 32'h50);
        tick();
        check("sw_imm", ex_imm_o, 32'hFFFF_FFF8);
        check("sw_rd", ex_rd_o, 0);
        check("sw_rdwe", ex_rd_we_o, 0);
        flush_i = 1'b1;
        drive(1, 32'h0010_00EF, 32'h54);
        check("flush_ready", if_ready_o, 0);
        tick();
        flush_i = 1'b0;
        check("flush_valid", ex_valid_o, 0);
        ex_ready_i = 1'b1;
        drive(1, 32'h0010_00EF, 32'h54);
        tick();
        drive(0, 32'h0, 32'h0);
        check("jal_pc", ex_pc_o, 32'h54);
        check("jal_imm", ex_imm_o, 32'h0000_0800);
        check("jal_rd", ex_rd_o, 1);

        // 5: writeback to x3 in the same cycle as ADD x4,x3,x0 decodes
        wb_en_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'hDEAD_BEEF;
        drive(1, 32'h0001_8233, 32'h58);
`ifdef WB_BYPASS_EN
        check("byp_ready", if_ready_o, 1);
        tick();
        wb_en_i = 1'b0;
`else
        check("wb_stall_ready", if_ready_o, 0);
        tick();
        wb_en_i = 1'b0;
        #1;
        check("wb_retry_ready", if_ready_o, 1);
        tick();
`endif
        drive(0, 32'h0, 32'h0);
        check("byp_pc", ex_pc_o, 32'h58);
        check("byp_rs1", ex_rs1_o, 32'hDEAD_BEEF);
        check("byp_rs2_x0", ex_rs2_o, 32'h0);

        // 6: BEQ x0,x0,-4096 then illegal opcode 0x7F
        drive(1, 32'h8000_0063, 32'h5C);
        tick();
        check("beq_imm", ex_imm_o, 32'hFFFF_F000);
        check("beq_rdwe", ex_rd_we_o, 0);
        check("beq_illegal", ex_illegal_o, 0);
        drive(1, 32'h0000_0FFF, 32'h60);
        tick();
        drive(0, 32'h0, 32'h0);
        check("ill_valid", ex_valid_o, 1);
        check("ill_flag", ex_illegal_o, 1);
        check("ill_rdwe", ex_rd_we_o, 0);
        check("ill_imm", ex_imm_o, 0);

        // Asynchronous reset in mid-cycle with the slot full
        ex_ready_i = 1'b0;
        drive(1, 32'hFFF0_0293, 32'h64);
        tick();
        check("pre_rst_valid", ex_valid_o, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", ex_valid_o, 0);
        check("async_rst_pc", ex_pc_o, 32'h0);
        check("async_rst_rdwe", ex_rd_we_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
